// File: rtl/shift_pkg.sv
// Shared definitions for the sequential right shifter.
//   SHIFT_N        : operand width
//   SHIFT_L        : shift-amount width, also the number of shift steps
//   shift_state_t  : controller states
package shift_pkg;
  localparam int SHIFT_N = 32;
  localparam int SHIFT_L = $clog2(SHIFT_N);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } shift_state_t;
endpackage

// File: rtl/shift_right_stage.sv
// One conditional right shift by the constant SH, with a selectable fill bit.
// Purely combinational.
//   d_i    : value to shift
//   en_i   : 1 = shift by SH, 0 = pass through
//   fill_i : bit shifted in at the top
//   q_o    : result
module shift_right_stage #(
  parameter int N  = 32,
  parameter int SH = 1
) (
  input  logic [N-1:0] d_i,
  input  logic         en_i,
  input  logic         fill_i,
  output logic [N-1:0] q_o
);
  always_comb begin
    q_o = d_i;
    if (en_i) q_o = {{SH{fill_i}}, d_i[N-1:SH]};
  end
endmodule

// File: rtl/shift_right_sequential.sv
// Sequential barrel shifter: one power-of-two step per cycle, always L steps,
// so latency is fixed regardless of the shift amount.
//   clk        : clock, rising edge
//   rst        : asynchronous reset, active low
//   in_valid   : request valid        in_ready : request accepted (S_IDLE)
//   in_data    : operand              shamt    : shift amount 0..N-1
//   arith      : 1 = sign fill, 0 = zero fill
//   out_valid  : result valid (S_DONE) out_ready : result consumed
//   out_data   : working register (meaningful only with out_valid)
// Build option: define SHIFT_RIGHT_ARITH_EN to honour 'arith'; without it
// every shift is logical. Timing and handshake are the same in both builds.
module shift_right_sequential
  import shift_pkg::*;
#(
  parameter int N = SHIFT_N,
  parameter int L = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic [L-1:0] shamt,
  input  logic         arith,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data
);
  localparam logic [L-1:0] K_LAST = L'(L-1);

  shift_state_t state_q, state_d;
  logic [L-1:0] k_q, k_d;
  logic [N-1:0] work_q, work_d;
  logic [L-1:0] shamt_q, shamt_d;
  logic         arith_q, arith_d;
  logic         sign_q, sign_d;
  logic         arith_eff;
  logic         fill;
  logic [N-1:0] step;
  logic [L-1:0][N-1:0] stage_q;

`ifdef SHIFT_RIGHT_ARITH_EN
  assign arith_eff = arith;
`else
  logic unused_arith;
  assign unused_arith = arith;
  assign arith_eff    = 1'b0;
`endif

  // Fill uses the sign of the operand as accepted, not of the partial result.
  assign fill = arith_q & sign_q;

  // Stage g shifts by 2^g; only the stage selected by k is used each cycle.
  for (genvar g = 0; g < L; g++) begin : g_stage
    shift_right_stage #(.N(N), .SH(1 << g)) u_stage (
      .d_i    (work_q),
      .en_i   (shamt_q[g]),
      .fill_i (fill),
      .q_o    (stage_q[g])
    );
  end

  always_comb begin
    step = work_q;
    for (int i = 0; i < L; i++)
      if (k_q == L'(i)) step = stage_q[i];
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      work_q  <= '0;
      shamt_q <= '0;
      arith_q <= 1'b0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      work_q  <= work_d;
      shamt_q <= shamt_d;
      arith_q <= arith_d;
      sign_q  <= sign_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    work_d  = work_q;
    shamt_d = shamt_q;
    arith_d = arith_q;
    sign_d  = sign_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_SHIFT;
          k_d     = '0;
          work_d  = in_data;
          shamt_d = shamt;
          arith_d = arith_eff;
          sign_d  = in_data[N-1];
        end
      end
      S_SHIFT: begin
        work_d = step;
        if (k_q == K_LAST) begin
          state_d = S_DONE;
          k_d     = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    out_data  = work_q;
  end
endmodule

// File: tb/tb_shift_right_sequential.sv
module tb_shift_right_sequential;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_data;
  logic [4:0]  shamt;
  logic        arith;
  logic        out_valid, out_ready;
  logic [31:0] out_data;

  int n_chk = 0;
  int n_err = 0;

  shift_right_sequential dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .shamt     (shamt),
    .arith     (arith),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present a request at a negedge, wait for the accepting edge, drop in_valid.
  task automatic send(input logic [31:0] d, input logic [4:0] sh, input logic ar);
    int w;
    @(negedge clk);
    w = 0;
    while (!in_ready && w < 20) begin @(negedge clk); w++; end
    chk("send_rdy", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_data = d; shamt = sh; arith = ar;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count edges after the accepting edge until out_valid (bounded).
  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!out_valid && lat < 20);
  endtask

  task automatic consume();
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    chk("idle_rdy", {31'd0, in_ready}, 32'd1);
    chk("idle_ov", {31'd0, out_valid}, 32'd0);
  endtask

  task automatic run(input string tag, input logic [31:0] d, input logic [4:0] sh,
                     input logic ar, input logic [31:0] exp);
    int lat;
    send(d, sh, ar);
    wait_done(lat);
    chk({tag, "_lat"}, lat, 32'd5);
    chk(tag, out_data, exp);
    consume();
  endtask

  initial begin
    int  lat;
    bit  seen;
    logic [31:0] held;
    rst = 1'b0; in_valid = 1'b0; in_data = '0; shamt = '0; arith = 1'b0; out_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_rdy", {31'd0, in_ready}, 32'd1);
    chk("rst_ov", {31'd0, out_valid}, 32'd0);
    chk("rst_data", out_data, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rel_rdy", {31'd0, in_ready}, 32'd1);
    chk("rel_ov", {31'd0, out_valid}, 32'd0);

    // Logical shifts
    run("log4", 32'hF000_0000, 5'd4, 1'b0, 32'h0F00_0000);
    run("log12", 32'h8765_4321, 5'd12, 1'b0, 32'h0008_7654);
    run("log31", 32'hFFFF_FFFF, 5'd31, 1'b0, 32'h0000_0001);

    // Arithmetic shifts
`ifdef SHIFT_RIGHT_ARITH_EN
    run("ari31", 32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF);
    run("ari12", 32'h8765_4321, 5'd12, 1'b1, 32'hFFF8_7654);
    run("ari19", 32'h8000_0000, 5'd19, 1'b1, 32'hFFFF_F000);
`else
    run("ari31", 32'h8000_0000, 5'd31, 1'b1, 32'h0000_0001);
    run("ari12", 32'h8765_4321, 5'd12, 1'b1, 32'h0008_7654);
    run("ari19", 32'h8000_0000, 5'd19, 1'b1, 32'h0000_1000);
`endif
    run("ari_pos", 32'h7000_0000, 5'd4, 1'b1, 32'h0700_0000);

    // in_valid held during shifting must not disturb the operation
    send(32'hF000_0000, 5'd4, 1'b0);
    in_valid = 1'b1; in_data = 32'hFFFF_FFFF; shamt = 5'd0; arith = 1'b1;
    wait_done(lat);
    in_valid = 1'b0;
    chk("busy_lat", lat, 32'd5);
    chk("busy_data", out_data, 32'h0F00_0000);
    consume();

    // Zero shift and backpressure
    send(32'h1234_5678, 5'd0, 1'b0);
    wait_done(lat);
    chk("zero_lat", lat, 32'd5);
    chk("zero_data", out_data, 32'h1234_5678);
    held = out_data;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i >= 3 && i < 7) begin
        in_valid = 1'b1; in_data = 32'hDEAD_BEEF; shamt = 5'd3; arith = 1'b0;
      end else in_valid = 1'b0;
      chk("bp_data", out_data, 32'h1234_5678);
      chk("bp_ov", {31'd0, out_valid}, 32'd1);
      chk("bp_rdy", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    consume();
    repeat (3) @(negedge clk);
    chk("bp_ign_ov", {31'd0, out_valid}, 32'd0);
    chk("bp_ign_data", out_data, held);

    // Reset mid-shift abandons the operation
    send(32'h8000_0000, 5'd31, 1'b1);
    @(posedge clk); @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    chk("mid_rst_rdy", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_ov", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_data", out_data, 32'd0);
    @(negedge clk); rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("mid_rst_nores", {31'd0, seen}, 32'd0);
    run("post_rst", 32'h0000_0100, 5'd8, 1'b0, 32'h0000_0001);

    // Back-to-back: request during consume is taken on the next idle cycle
    send(32'h0000_00F0, 5'd4, 1'b0);
    wait_done(lat);
    chk("b2b1_data", out_data, 32'h0000_000F);
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'hAAAA_0000; shamt = 5'd16; arith = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("b2b_not_acc", {31'd0, in_ready}, 32'd1);
    chk("b2b_ov", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b_acc", {31'd0, in_ready}, 32'd0);
    wait_done(lat);
    chk("b2b2_lat", lat, 32'd5);
    chk("b2b2_data", out_data, 32'h0000_AAAA);
    consume();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
